joy_dir_filter: RTL and testbench

//  Multi-player joystick conditioner between the hps_io/DB15/keyboard merge and the game core.
//  Per player: synchronises, debounces, restricts directions per a runtime mode and adds autofire.

---
 rtl/joy_dir_filter.sv | 178 +++++++++++++++++
 tb/tb_joy_dir_filter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/joy_dir_filter.sv
// Multi-player joystick conditioner: input synchroniser, per-bit debounce,
// runtime direction restriction (pass / 4-way last / 4-way first / SOCD)
// and per-player autofire. All outputs are registered.
module joy_dir_filter #(
  parameter int NUM_PLAYERS = 2,
  parameter int DEB_CYCLES  = 0,
  parameter int AF_DIV      = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [1:0]               mode,
  input  logic [5*NUM_PLAYERS-1:0] din,
  input  logic [NUM_PLAYERS-1:0]   autofire_en,
  input  logic                     af_tick,
  output logic [5*NUM_PLAYERS-1:0] dout
);

  localparam int         W          = 5 * NUM_PLAYERS;
  localparam int         AFW        = (AF_DIV > 1) ? $clog2(AF_DIV) : 1;
  localparam logic [1:0] MODE_PASS  = 2'd0;
  localparam logic [1:0] MODE_LAST  = 2'd1;
  localparam logic [1:0] MODE_FIRST = 2'd2;
  localparam logic [1:0] MODE_SOCD  = 2'd3;

  // One-hot of the highest-priority set direction (up > down > left > right).
  function automatic logic [3:0] pri_dir(input logic [3:0] x);
    logic [3:0] r;
    if (x[3])      r = 4'b1000;
    else if (x[2]) r = 4'b0100;
    else if (x[1]) r = 4'b0010;
    else if (x[0]) r = 4'b0001;
    else           r = 4'b0000;
    return r;
  endfunction

  logic [W-1:0] s1_r;
  logic [W-1:0] db_r;
  logic [1:0]   mode_q_r;
  logic         mode_chg_s;

  // First synchroniser stage for every raw control bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) s1_r <= '0;
    else          s1_r <= din;
  end

  generate
    if (DEB_CYCLES <= 1) begin : g_nodeb
      // Without debounce the second stage is a plain register.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) db_r <= '0;
        else          db_r <= s1_r;
      end
    end else begin : g_deb
      localparam int CW = $clog2(DEB_CYCLES + 1);
      for (genvar b = 0; b < W; b++) begin : g_bit
        logic [CW-1:0] cnt_r;
        logic          db_bit_r;
        assign db_r[b] = db_bit_r;
        // Accept a new level only after it has differed from db for DEB_CYCLES edges.
        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) begin
            cnt_r    <= '0;
            db_bit_r <= 1'b0;
          end else if (s1_r[b] == db_bit_r) begin
            cnt_r <= '0;
          end else if (cnt_r == CW'(DEB_CYCLES - 1)) begin
            db_bit_r <= s1_r[b];
            cnt_r    <= '0;
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
      end
    end
  endgenerate

  // Remember the previous mode so a mode switch can release every held mask.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) mode_q_r <= 2'd0;
    else          mode_q_r <= mode;
  end

  assign mode_chg_s = (mode != mode_q_r);

  generate
    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_pl
      logic [3:0]     d_s;
      logic [3:0]     dq_r;
      logic [3:0]     newp_s;
      logic [3:0]     mask_r;
      logic [3:0]     mask_eff_s;
      logic [3:0]     mask_nx_s;
      logic [3:0]     dir_s;
      logic           fire_db_s;
      logic           fire_s;
      logic           af_phase_r;
      logic [AFW-1:0] af_cnt_r;
      logic [4:0]     out_r;

      assign d_s       = db_r[5*p +: 4];
      assign fire_db_s = db_r[5*p + 4];
      assign newp_s    = d_s & ~dq_r;
      assign dout[5*p +: 5] = out_r;

      // Direction restriction: choose the allowed-direction mask for this update.
      always_comb begin
        mask_eff_s = mode_chg_s ? 4'b1111 : mask_r;
        mask_nx_s  = 4'b1111;
        dir_s      = d_s;
        case (mode)
          MODE_LAST, MODE_FIRST: begin
            if (((d_s & mask_eff_s) == 4'b0000) || (mask_eff_s == 4'b1111)) begin
              if (d_s != 4'b0000) mask_nx_s = pri_dir(d_s);
              else                mask_nx_s = 4'b1111;
            end else if ((mode == MODE_LAST) && (newp_s != 4'b0000)) begin
              mask_nx_s = pri_dir(newp_s);
            end else begin
              mask_nx_s = mask_eff_s;
            end
            dir_s = d_s & mask_nx_s;
          end
          MODE_SOCD: begin
            mask_nx_s  = 4'b1111;
            dir_s[3:2] = (d_s[3] && d_s[2]) ? 2'b00 : d_s[3:2];
            dir_s[1:0] = (d_s[1] && d_s[0]) ? 2'b00 : d_s[1:0];
          end
          MODE_PASS: begin
            mask_nx_s = 4'b1111;
            dir_s     = d_s;
          end
          default: begin
            mask_nx_s = 4'b1111;
            dir_s     = d_s;
          end
        endcase
      end

      // Previous debounced directions and the held mask.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          dq_r   <= 4'b0000;
          mask_r <= 4'b1111;
        end else begin
          dq_r   <= d_s;
          mask_r <= mask_nx_s;
        end
      end

      // Autofire timebase: phase starts high on press, toggles every AF_DIV ticks.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          af_cnt_r   <= '0;
          af_phase_r <= 1'b1;
        end else if (!fire_db_s || !autofire_en[p]) begin
          af_cnt_r   <= '0;
          af_phase_r <= 1'b1;
        end else if (af_tick) begin
          if (af_cnt_r == AFW'(AF_DIV - 1)) begin
            af_cnt_r   <= '0;
            af_phase_r <= ~af_phase_r;
          end else begin
            af_cnt_r <= af_cnt_r + 1'b1;
          end
        end
      end

      assign fire_s = fire_db_s & (autofire_en[p] ? af_phase_r : 1'b1);

      // Registered player output.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) out_r <= 5'b00000;
        else          out_r <= {fire_s, dir_s};
      end
    end
  endgenerate

endmodule

// File: tb/tb_joy_dir_filter.sv
// Self-checking bench for joy_dir_filter: directed vector table, hand-written
// timing sequences and randomized stimulus against a behavioural model.
module tb_joy_dir_filter;

  localparam int NP    = 2;
  localparam int W     = 5 * NP;
  localparam int DEB_A = 0;
  localparam int AFD_A = 2;
  localparam int DEB_B = 4;
  localparam int AFD_B = 3;

  logic          clk;
  logic          reset_n;
  logic [1:0]    mode;
  logic [W-1:0]  din;
  logic [NP-1:0] af_en;
  logic          af_tick;
  logic [W-1:0]  dout_a;
  logic [W-1:0]  dout_b;

  int checks = 0;
  int errors = 0;

  joy_dir_filter #(.NUM_PLAYERS(NP), .DEB_CYCLES(DEB_A), .AF_DIV(AFD_A)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .mode(mode), .din(din),
    .autofire_en(af_en), .af_tick(af_tick), .dout(dout_a));

  joy_dir_filter #(.NUM_PLAYERS(NP), .DEB_CYCLES(DEB_B), .AF_DIV(AFD_B)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .mode(mode), .din(din),
    .autofire_en(af_en), .af_tick(af_tick), .dout(dout_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [W-1:0] m_s1   [2];
  logic [W-1:0] m_db   [2];
  logic [W-1:0] m_dbq  [2];
  logic [W-1:0] m_dout [2];
  logic [W-1:0] m_hist [2][8];
  int           m_sel  [2][NP];
  int           m_ticks[2][NP];
  logic [1:0]   m_modeq;

  function automatic int top_dir(input logic [3:0] x);
    for (int i = 3; i >= 0; i--) if (x[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_s1[k] = '0; m_db[k] = '0; m_dbq[k] = '0; m_dout[k] = '0;
      for (int i = 0; i < 8; i++) m_hist[k][i] = '0;
      for (int p = 0; p < NP; p++) begin
        m_sel[k][p] = -1;
        m_ticks[k][p] = 0;
      end
    end
    m_modeq = 2'd0;
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      logic [W-1:0] nd;
      int deb;
      int afd;
      deb = (k == 0) ? DEB_A : DEB_B;
      afd = (k == 0) ? AFD_A : AFD_B;
      nd = '0;
      for (int p = 0; p < NP; p++) begin
        logic [3:0] d;
        logic [3:0] fresh;
        logic [3:0] dirs;
        logic       f;
        logic       ph;
        int         s;
        d     = m_db[k][5*p +: 4];
        fresh = d & ~m_dbq[k][5*p +: 4];
        f     = m_db[k][5*p + 4];
        s     = (mode != m_modeq) ? -1 : m_sel[k][p];
        dirs  = d;
        if (mode == 2'd1 || mode == 2'd2) begin
          if (s < 0) s = top_dir(d);
          else if (!d[s]) s = top_dir(d);
          else if (mode == 2'd1 && fresh != 4'b0000) s = top_dir(fresh);
          dirs = (s < 0) ? 4'b0000 : (4'b0001 << s);
        end else begin
          s = -1;
          if (mode == 2'd3) begin
            if (d[3] && d[2]) dirs[3:2] = 2'b00;
            if (d[1] && d[0]) dirs[1:0] = 2'b00;
          end
        end
        ph = (((m_ticks[k][p] / afd) % 2) == 0);
        nd[5*p +: 5] = {f & (af_en[p] ? ph : 1'b1), dirs};
        if (!f || !af_en[p]) m_ticks[k][p] = 0;
        else if (af_tick) m_ticks[k][p] = m_ticks[k][p] + 1;
        m_sel[k][p] = s;
      end
      m_dbq[k] = m_db[k];
      for (int i = 7; i > 0; i--) m_hist[k][i] = m_hist[k][i-1];
      m_hist[k][0] = m_s1[k];
      if (deb <= 1) begin
        m_db[k] = m_s1[k];
      end else begin
        for (int b = 0; b < W; b++) begin
          bit stable;
          stable = 1'b1;
          for (int i = 0; i < deb; i++)
            if (m_hist[k][i][b] == m_db[k][b]) stable = 1'b0;
          if (stable) m_db[k][b] = m_hist[k][0][b];
        end
      end
      m_s1[k]   = din;
      m_dout[k] = nd;
    end
    m_modeq = mode;
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", name, got, exp);
    end
  endtask

  task automatic tick1();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick1();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    mode = 2'd0; din = '0; af_en = '0; af_tick = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("reset_a", dout_a, '0);
    chk("reset_b", dout_b, '0);
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic [1:0]    mode;
    logic [W-1:0]  din;
    logic [NP-1:0] en;
    logic [W-1:0]  exp;
  } vec_t;

  vec_t vt [8];

  initial begin
    reset_n = 1'b0; mode = 2'd0; din = '0; af_en = '0; af_tick = 1'b0;
    model_reset();

    vt[0] = '{2'd0, 10'b00000_11111, 2'b00, 10'b00000_11111};
    vt[1] = '{2'd1, 10'b00000_01111, 2'b00, 10'b00000_01000};
    vt[2] = '{2'd2, 10'b00101_01111, 2'b00, 10'b00100_01000};
    vt[3] = '{2'd3, 10'b01100_01001, 2'b00, 10'b00000_01001};
    vt[4] = '{2'd3, 10'b00111_01111, 2'b00, 10'b00100_00000};
    vt[5] = '{2'd0, 10'b00000_00000, 2'b00, 10'b00000_00000};
    vt[6] = '{2'd1, 10'b10010_00000, 2'b10, 10'b10010_00000};
    vt[7] = '{2'd1, 10'b00000_00000, 2'b10, 10'b00000_00000};

    do_reset();

    // Table-driven steady-state vectors on the undebounced instance.
    for (int i = 0; i < 8; i++) begin
      mode = vt[i].mode; din = vt[i].din; af_en = vt[i].en;
      ticks(5);
      chk($sformatf("vec%0d", i), dout_a, vt[i].exp);
    end

    // LAST: right held, then up pressed, then up released.
    do_reset();
    mode = 2'd1; ticks(2);
    din = 10'b00000_00001;
    ticks(2); chk("last_lat_early", dout_a, 10'b00000_00000);
    tick1();  chk("last_right",     dout_a, 10'b00000_00001);
    din = 10'b00000_01001;
    ticks(2); chk("last_up_early",  dout_a, 10'b00000_00001);
    tick1();  chk("last_up",        dout_a, 10'b00000_01000);
    din = 10'b00000_00001;
    ticks(3); chk("last_up_rel",    dout_a, 10'b00000_00001);

    // FIRST: held right kept while up added; released right hands over to up.
    mode = 2'd2; ticks(4); chk("first_right", dout_a, 10'b00000_00001);
    din = 10'b00000_01001;
    ticks(4); chk("first_keep", dout_a, 10'b00000_00001);
    din = 10'b00000_01000;
    ticks(2); chk("first_rel_early", dout_a, 10'b00000_00001);
    tick1();  chk("first_handover",  dout_a, 10'b00000_01000);

    // SOCD on player 1.
    mode = 2'd3; din = 10'b01011_00000;
    ticks(4); chk("socd_lr_up", dout_a, 10'b01000_00000);
    din = 10'b01111_00000;
    ticks(4); chk("socd_all", dout_a, 10'b00000_00000);

    // Debounce on the DEB_CYCLES=4 instance: 3-clk glitch then 4-clk stable press.
    do_reset();
    din = 10'b00000_10000; ticks(3);
    din = 10'b00000_00000;
    for (int i = 0; i < 8; i++) begin
      tick1(); chk("deb_glitch", dout_b & 10'b00000_10000, 10'b0);
    end
    din = 10'b00000_10000;
    ticks(5); chk("deb_press_early", dout_b & 10'b00000_10000, 10'b0);
    tick1();  chk("deb_press", dout_b & 10'b00000_10000, 10'b00000_10000);

    // Autofire on player 0 only, AF_DIV=2 instance, tick every 10 clks.
    do_reset();
    af_en = 2'b01; din = 10'b10000_10000;
    ticks(3); chk("af_press", dout_a & 10'b10000_10000, 10'b10000_10000);
    for (int t = 1; t <= 4; t++) begin
      logic [W-1:0] e;
      af_tick = 1'b1; tick1(); af_tick = 1'b0;
      ticks(9);
      e = 10'b10000_00000;
      if (((t / 2) % 2) == 0) e[4] = 1'b1;
      chk($sformatf("af_tick%0d", t), dout_a & 10'b10000_10000, e);
    end

    // Mode change releases held masks; async reset clears immediately.
    do_reset();
    mode = 2'd1; din = 10'b00000_01000;
    ticks(4); chk("mc_up", dout_a, 10'b00000_01000);
    din = 10'b00000_01010;
    ticks(4); chk("mc_left", dout_a, 10'b00000_00010);
    mode = 2'd2;
    tick1();  chk("mc_switch", dout_a, 10'b00000_01000);
    ticks(2); chk("mc_hold", dout_a, 10'b00000_01000);
    #2 reset_n = 1'b0;
    #1 chk("async_rst_a", dout_a, '0);
    chk("async_rst_b", dout_b, '0);
    model_reset();
    @(negedge clk);
    mode = 2'd0; din = '0; af_en = '0;
    reset_n = 1'b1;

    // Randomized run against the behavioural model.
    for (int c = 0; c < 1500; c++) begin
      logic [W-1:0] fl;
      fl = '0;
      for (int b = 0; b < W; b++) if ($urandom_range(0, 5) == 0) fl[b] = 1'b1;
      din = din ^ fl;
      af_tick = ($urandom_range(0, 6) == 0);
      if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) af_en = 2'($urandom_range(0, 3));
      tick1();
      chk("rnd_a", dout_a, m_dout[0]);
      chk("rnd_b", dout_b, m_dout[1]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
